inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Instruction fetch front end. Issues sequential word fetches on the inst SRAM-like req/addr_ok/data_ok
//  interface of the AXI transfer bridge and reorders nothing; responses return in order into a ring of entries.
//  Presents {pc, inst} to decode with a valid/ready handshake. Redirects (branch/exception) flush the queue
//  and silently drop responses still in flight.
// PARAMETERS
//  DEPTH      4              ring entries = max (buffered + in-flight + to-be-discarded) requests
//  PTR_WIDTH  2              log2(DEPTH); occupancy/discard counters are PTR_WIDTH+1 bits
//  RESET_PC   32'h1c000000   first fetch address after reset
// PORTS
//  clk                input   1   clock
//  reset              input   1   synchronous, active-high reset
//  redirect_valid     input   1   flush queue, restart fetch at redirect_pc
//  redirect_pc        input   32  new fetch address (word aligned)
//  inst_sram_req      output  1   fetch request valid
//  inst_sram_wr       output  1   tied 0
//  inst_sram_size     output  2   tied 2'd2 (4 bytes)
//  inst_sram_addr     output  32  fetch address
//  inst_sram_wstrb    output  4   tied 0
//  inst_sram_wdata    output  32  tied 0
//  inst_sram_addr_ok  input   1   request accepted this cycle (req && addr_ok = issue)
//  inst_sram_data_ok  input   1   one in-order response this cycle
//  inst_sram_rdata    input   32  response data, valid with data_ok
//  fs_valid           output  1   head entry holds a returned instruction
//  fs_pc              output  32  pc of head entry
//  fs_inst            output  32  instruction of head entry
//  fs_ready           input   1   decode consumes head when fs_valid && fs_ready
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; head/fill/tail ptrs=0; discard_cnt=0; all entry valids=0.
//    Outputs after reset: inst_sram_req=0 in the reset cycle, fs_valid=0, fs_pc=0, fs_inst=0.
//  - Ring: tail = next entry to issue, fill = oldest issued-not-returned, head = oldest returned.
//    occ = tail-head (PTR_WIDTH+1 bits, wraps mod 2*DEPTH). Pointers wrap DEPTH-1 -> 0.
//  - Issue: inst_sram_req = !reset && (occ + discard_cnt < DEPTH); inst_sram_addr = fetch_pc.
//    On req && addr_ok: entry[tail].pc<=fetch_pc, tail++, fetch_pc<=fetch_pc+4 (mod 2^32).
//    Without addr_ok, req and addr are held stable until accepted or redirected.
//  - Response: on data_ok: if discard_cnt>0, discard_cnt-- and drop data; else entry[fill].inst<=rdata,
//    entry[fill].done<=1, fill++. Latency data_ok -> fs_valid = 1 cycle (registered).
//  - Output: fs_valid = entry[head].done && (head!=fill || full-returned). Pop on fs_valid&&fs_ready: head++,
//    done cleared. Push (issue) and pop in the same cycle at occ==DEPTH are legal; net occ unchanged.
//  - Redirect (highest priority over issue/pop effects): head=fill=tail<=0 (all entries cleared),
//    fetch_pc<=redirect_pc, discard_cnt <= (tail-fill) + issue_this_cycle - (data_ok && discard_cnt==0 ? 1:0)
//    + (discard_cnt - (data_ok && discard_cnt>0 ? 1:0)); i.e. every request accepted but not yet returned,
//    including one accepted in the redirect cycle, is discarded; a data_ok in the redirect cycle is dropped.
//    fs_valid=0 in the cycle after redirect. inst_sram_req may be asserted in the redirect cycle but its
//    address is the old fetch_pc and it is counted for discard.
//  - Invariant: occ + discard_cnt <= DEPTH at all times; data_ok with occ-unfilled==0 and discard_cnt==0 is
//    a protocol error (assertion, no state change).
//  - Reset mid-operation clears everything; the bridge is reset together, so no stale responses arrive.
// STRUCTURE
//  - Shared header mycpu.vh: `RESET_PC, `INST_SIZE_WORD (2'd2), fetch bus width macros.
//  - One sub-module: prefetch_ring (DEPTH x {pc, inst, done} storage + head/fill/tail pointers, occ);
//    top level holds fetch_pc, discard_cnt, issue and redirect control.
// TESTING
//  1 Reset, addr_ok=1 always, data_ok 2 cycles after issue, fs_ready=1 -> fs_pc 1c000000,1c000004,.. one/cycle.
//  2 fs_ready=0 -> exactly DEPTH=4 issues, then req=0; fs_ready=1 one cycle -> one pop, one new issue.
//  3 addr_ok=0 for 5 cycles -> req=1, addr=1c000000 stable all 5 cycles; accept -> next addr 1c000004.
//  4 3 requests in flight, redirect_pc=1c000100 -> next 3 data_ok dropped, first fs_pc=1c000100.
//  5 redirect in same cycle as addr_ok and data_ok -> that data dropped, accepted request discarded, no overflow.
//  6 reset asserted with 2 in flight and 2 buffered -> next cycle fs_valid=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// This package stands in for the old mycpu.vh macros: reset PC, fetch size and fetch bus widths.
package inst_prefetch_queue_pkg;
  localparam int               FETCH_AW       = 32;
  localparam int               FETCH_DW       = 32;
  localparam int               DEPTH_DEF      = 4;
  localparam int               PTR_WIDTH_DEF  = 2;
  localparam logic [31:0]      RESET_PC_DEF   = 32'h1c000000;
  localparam logic [1:0]       INST_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] inst;
    logic                done;
  } entry_t;

  function automatic logic [FETCH_AW-1:0] next_pc(input logic [FETCH_AW-1:0] pc);
    return pc + FETCH_AW'(4);
  endfunction
endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch bus to the transfer bridge plus the decode-side {pc, inst} handshake.
interface inst_prefetch_queue_if;
  import inst_prefetch_queue_pkg::*;
  logic                inst_sram_req;
  logic                inst_sram_wr;
  logic [1:0]          inst_sram_size;
  logic [FETCH_AW-1:0] inst_sram_addr;
  logic [3:0]          inst_sram_wstrb;
  logic [FETCH_DW-1:0] inst_sram_wdata;
  logic                inst_sram_addr_ok;
  logic                inst_sram_data_ok;
  logic [FETCH_DW-1:0] inst_sram_rdata;
  logic                fs_valid;
  logic [FETCH_AW-1:0] fs_pc;
  logic [FETCH_DW-1:0] fs_inst;
  logic                fs_ready;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_valid, fs_pc, fs_inst,
    input  fs_ready
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_valid, fs_pc, fs_inst,
    output fs_ready
  );
endinterface

// File: rtl/inst_prefetch_queue_ring.sv
// Ring of DEPTH {pc, inst, done} entries with head (oldest returned), fill (oldest
// outstanding) and tail (next to issue) pointers; pointers carry one extra wrap bit.
module prefetch_ring
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic [FETCH_AW-1:0] push_pc,
  input  logic                fill,
  input  logic [FETCH_DW-1:0] fill_inst,
  input  logic                pop,
  output logic                head_valid,
  output logic [FETCH_AW-1:0] head_pc,
  output logic [FETCH_DW-1:0] head_inst,
  output logic [PTR_WIDTH:0]  occ,
  output logic [PTR_WIDTH:0]  unfilled
);
  typedef logic [PTR_WIDTH:0] ptr_t;

  ptr_t   head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [PTR_WIDTH-1:0] head_idx, fill_idx, tail_idx;
  assign head_idx = head_q[PTR_WIDTH-1:0];
  assign fill_idx = fill_q[PTR_WIDTH-1:0];
  assign tail_idx = tail_q[PTR_WIDTH-1:0];

  assign occ        = tail_q - head_q;
  assign unfilled   = tail_q - fill_q;
  // done alone is not enough when head==fill after a full wrap; the pointer test disambiguates
  assign head_valid = ent_q[head_idx].done && (fill_q != head_q);
  assign head_pc    = ent_q[head_idx].pc;
  assign head_inst  = ent_q[head_idx].inst;

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    ent_d  = ent_q;
    if (clear) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end else begin
      if (push) begin
        ent_d[tail_idx].pc = push_pc;
        tail_d             = tail_q + ptr_t'(1);
      end
      if (fill) begin
        ent_d[fill_idx].inst = fill_inst;
        ent_d[fill_idx].done = 1'b1;
        fill_d               = fill_q + ptr_t'(1);
      end
      if (pop) begin
        ent_d[head_idx].done = 1'b0;
        head_d               = head_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, buffers in-order
// responses in a ring, and discards responses that belong to a flushed stream.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEF,
  parameter int          PTR_WIDTH = PTR_WIDTH_DEF,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [FETCH_AW-1:0]   redirect_pc,
  inst_prefetch_queue_if.master bus
);
  typedef logic [PTR_WIDTH:0] cnt_t;
  localparam logic [PTR_WIDTH+1:0] DEPTH_W = (PTR_WIDTH+2)'(DEPTH);

  logic [FETCH_AW-1:0]  fetch_pc_q, fetch_pc_d;
  cnt_t                 discard_q, discard_d;
  cnt_t                 occ, unfilled;
  logic [PTR_WIDTH+1:0] budget;
  logic                 req, issue, fill_en, drop, pop;
  logic                 head_valid;
  logic [FETCH_AW-1:0]  head_pc;
  logic [FETCH_DW-1:0]  head_inst;

  // ring slots are shared between live entries and responses still owed to a flushed stream
  assign budget  = {1'b0, occ} + {1'b0, discard_q};
  assign req     = !reset && (budget < DEPTH_W);
  assign issue   = req && bus.inst_sram_addr_ok;
  assign drop    = bus.inst_sram_data_ok && (discard_q != '0);
  assign fill_en = bus.inst_sram_data_ok && (discard_q == '0) && (unfilled != '0);
  assign pop     = head_valid && bus.fs_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q - cnt_t'(drop);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      // everything still owed by the bridge after this cycle, including a same-cycle issue
      discard_d  = unfilled + discard_q + cnt_t'(issue) - cnt_t'(fill_en | drop);
    end else if (issue) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  prefetch_ring #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (issue),
    .push_pc    (fetch_pc_q),
    .fill       (fill_en),
    .fill_inst  (bus.inst_sram_rdata),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .occ        (occ),
    .unfilled   (unfilled)
  );

  assign bus.inst_sram_req   = req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = INST_SIZE_WORD;
  assign bus.inst_sram_addr  = fetch_pc_q;
  assign bus.inst_sram_wstrb = '0;
  assign bus.inst_sram_wdata = '0;
  assign bus.fs_valid        = head_valid;
  assign bus.fs_pc           = head_pc;
  assign bus.fs_inst         = head_inst;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(bus.inst_sram_data_ok && unfilled == '0 && discard_q == '0));
  a_slot_budget: assert property (@(posedge clk) disable iff (reset) budget <= DEPTH_W);
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed vector table, corner sequences, and random
// traffic checked against a queue-based model of fetch/return/flush behaviour.
module tb_inst_prefetch_queue;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  inst_prefetch_queue_if bus_if();

  inst_prefetch_queue #(.DEPTH(4), .PTR_WIDTH(2), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aok, dok, rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fsv;
    logic [31:0] e_pc;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  logic want_dok, lat2;
  logic [31:0] br_addr[$];
  int          br_t[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic [31:0] m_bpc[$];
  int          m_disc;
  logic        e_req, e_fsv;
  vec_t        tbl[19];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic vec_t mk(input int aok, dok, rdy, ereq, int aoff, int efsv, int poff);
    vec_t v;
    v.aok = (aok != 0); v.dok = (dok != 0); v.rdy = (rdy != 0);
    v.e_req = (ereq != 0); v.e_addr = RPC + 32'(aoff);
    v.e_fsv = (efsv != 0); v.e_pc = RPC + 32'(poff);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cur_dok();
    if (!want_dok || reset || br_addr.size() == 0) return 1'b0;
    if (lat2 && (cyc - br_t[0] < 2)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_in(input logic rst, aok, wd, rdy);
    reset = rst; redirect_valid = 1'b0;
    bus_if.inst_sram_addr_ok = aok; want_dok = wd; bus_if.fs_ready = rdy;
  endtask

  // drive bridge response, let outputs settle, derive model expectations
  task automatic settle();
    logic dok;
    dok = cur_dok();
    bus_if.inst_sram_data_ok = dok;
    bus_if.inst_sram_rdata   = dok ? mem(br_addr[0]) : $urandom;
    #3;
    e_req = !reset && (m_pend.size() + m_bpc.size() + m_disc < 4);
    e_fsv = m_bpc.size() > 0;
  endtask

  task automatic model_check();
    chk("req", bus_if.inst_sram_req, e_req);
    if (e_req) chk("addr", bus_if.inst_sram_addr, m_pc);
    chk("fs_valid", bus_if.fs_valid, e_fsv);
    if (e_fsv) begin
      chk("fs_pc", bus_if.fs_pc, m_bpc[0]);
      chk("fs_inst", bus_if.fs_inst, mem(m_bpc[0]));
    end
  endtask

  task automatic edge_update();
    logic dok, aok, rdy, dut_iss;
    logic [31:0] dut_addr, tmp;
    dok = bus_if.inst_sram_data_ok; aok = bus_if.inst_sram_addr_ok; rdy = bus_if.fs_ready;
    dut_iss = bus_if.inst_sram_req && aok; dut_addr = bus_if.inst_sram_addr;
    @(posedge clk);
    if (reset) begin
      m_pc = RPC; m_pend.delete(); m_bpc.delete(); m_disc = 0;
      br_addr.delete(); br_t.delete();
    end else begin
      if (dok) begin tmp = br_addr.pop_front(); void'(br_t.pop_front()); end
      if (dut_iss) begin br_addr.push_back(dut_addr); br_t.push_back(cyc); end
      if (dok) begin
        if (m_disc > 0) m_disc--;
        else if (m_pend.size() > 0) begin tmp = m_pend.pop_front(); m_bpc.push_back(tmp); end
      end
      if (e_fsv && rdy) tmp = m_bpc.pop_front();
      if (e_req && aok) begin m_pend.push_back(m_pc); m_pc = m_pc + 32'd4; end
      if (redirect_valid) begin
        // every request the bridge still owes becomes a discard
        m_disc = m_disc + m_pend.size();
        m_pend.delete(); m_bpc.delete(); m_pc = redirect_pc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step(); settle(); model_check(); edge_update(); endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0); settle(); edge_update();
    settle(); model_check(); edge_update();
    reset = 1'b0;
  endtask

  task automatic watch_first(input string nm, input logic [31:0] exp, input int maxc, output int doks);
    logic got;
    got = 1'b0; doks = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      settle(); model_check();
      if (bus_if.fs_valid) begin got = 1'b1; chk(nm, bus_if.fs_pc, exp); end
      else if (bus_if.inst_sram_data_ok) doks++;
      edge_update();
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int npop, d;
    tbl[0]  = mk(0,0,0, 1,'h00, 0,0);   tbl[1]  = mk(0,0,0, 1,'h00, 0,0);
    tbl[2]  = mk(0,0,0, 1,'h00, 0,0);   tbl[3]  = mk(0,0,0, 1,'h00, 0,0);
    tbl[4]  = mk(0,0,0, 1,'h00, 0,0);   tbl[5]  = mk(1,0,0, 1,'h00, 0,0);
    tbl[6]  = mk(1,0,0, 1,'h04, 0,0);   tbl[7]  = mk(1,1,0, 1,'h08, 0,0);
    tbl[8]  = mk(1,0,0, 1,'h0c, 1,'h00); tbl[9]  = mk(1,1,0, 0,0, 1,'h00);
    tbl[10] = mk(1,1,0, 0,0, 1,'h00);   tbl[11] = mk(1,0,1, 0,0, 1,'h00);
    tbl[12] = mk(1,0,0, 1,'h10, 1,'h04); tbl[13] = mk(1,1,0, 0,0, 1,'h04);
    tbl[14] = mk(0,0,1, 0,0, 1,'h04);   tbl[15] = mk(0,0,1, 1,'h14, 1,'h08);
    tbl[16] = mk(0,0,1, 1,'h14, 1,'h0c); tbl[17] = mk(0,1,1, 1,'h14, 0,0);
    tbl[18] = mk(0,0,1, 1,'h14, 1,'h10);

    redirect_pc = '0; lat2 = 1'b0; m_pc = RPC; m_disc = 0;
    set_in(1, 0, 0, 0);
    bus_if.inst_sram_data_ok = 1'b0; bus_if.inst_sram_rdata = '0;
    #1;
    do_reset();
    chk("rst_fs_pc", bus_if.fs_pc, 32'h0);
    chk("rst_fs_inst", bus_if.fs_inst, 32'h0);
    chk("tie_wr", 32'(bus_if.inst_sram_wr), 32'h0);
    chk("tie_size", 32'(bus_if.inst_sram_size), 32'd2);
    chk("tie_wstrb", 32'(bus_if.inst_sram_wstrb), 32'h0);
    chk("tie_wdata", bus_if.inst_sram_wdata, 32'h0);

    // addr_ok stall then backpressure to a full ring
    for (int i = 0; i < 19; i++) begin
      set_in(0, tbl[i].aok, tbl[i].dok, tbl[i].rdy);
      settle();
      chk($sformatf("tbl%0d_req", i), 32'(bus_if.inst_sram_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), bus_if.inst_sram_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_fsv", i), 32'(bus_if.fs_valid), 32'(tbl[i].e_fsv));
      if (tbl[i].e_fsv) begin
        chk($sformatf("tbl%0d_pc", i), bus_if.fs_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_inst", i), bus_if.fs_inst, mem(tbl[i].e_pc));
      end
      edge_update();
    end

    // streaming: one instruction per cycle once the pipe fills
    do_reset(); lat2 = 1'b1; npop = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, 1, 1); settle(); model_check();
      if (bus_if.fs_valid) begin
        chk("seq_pc", bus_if.fs_pc, RPC + 32'(4 * npop));
        npop++;
      end
      edge_update();
    end
    chk("seq_pops", 32'(npop), 32'd17);

    // redirect with three requests in flight
    do_reset(); lat2 = 1'b0;
    for (int i = 0; i < 3; i++) begin set_in(0, 1, 0, 1); step(); end
    set_in(0, 0, 0, 1); redirect_valid = 1'b1; redirect_pc = 32'h1c000100; step();
    lat2 = 1'b1; set_in(0, 1, 1, 1);
    watch_first("redir_first_pc", 32'h1c000100, 20, d);
    chk("redir_drops", 32'(d), 32'd4);

    // redirect coinciding with an accept and a response
    do_reset(); lat2 = 1'b1;
    for (int i = 0; i < 2; i++) begin set_in(0, 1, 1, 0); step(); end
    set_in(0, 1, 1, 0); redirect_valid = 1'b1; redirect_pc = 32'h1c000200;
    settle();
    chk("same_cyc_dok", 32'(bus_if.inst_sram_data_ok), 32'd1);
    model_check(); edge_update();
    set_in(0, 1, 1, 1);
    watch_first("same_cyc_first_pc", 32'h1c000200, 20, d);
    chk("same_cyc_drops", 32'(d), 32'd3);

    // reset with two buffered and two in flight
    do_reset(); lat2 = 1'b1;
    for (int i = 0; i < 4; i++) begin set_in(0, 1, 1, 0); step(); end
    set_in(1, 1, 0, 0); step();
    set_in(0, 0, 0, 1); settle();
    chk("mid_rst_fsv", 32'(bus_if.fs_valid), 32'd0);
    chk("mid_rst_pc", bus_if.fs_pc, 32'h0);
    chk("mid_rst_req", 32'(bus_if.inst_sram_req), 32'd1);
    chk("mid_rst_addr", bus_if.inst_sram_addr, RPC);
    model_check(); edge_update();

    // random traffic against the model
    lat2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      if (!reset && $urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom & 32'hffff_fffc;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
